spi_slave_sync: RTL and testbench

SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

---
 rtl/spi_slave_sync_pkg.sv | 21 ++
 rtl/spi_slave_sync_bit.sv | 33 +++
 rtl/spi_slave_sync.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_sync_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_sync_pkg
// Shared definitions for the clk-domain SPI slave: FSM state type, SPI
// mode-0 constants and the default word length / synchroniser depth.
// Optional feature macro used by the slice: SPI_SLAVE_SYNC_OVERRUN_EN.
// ---------------------------------------------------------------------------
package spi_slave_sync_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // SPI mode 0: sck idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_sync_bit.sv
// ---------------------------------------------------------------------------
// spi_sync_bit
// STAGES-deep flop chain bringing one asynchronous input into the clk domain.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset, loads RST_VAL into every stage
//   d_i  - asynchronous input
//   q_o  - synchronised output (last stage)
// ---------------------------------------------------------------------------
module spi_sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// ---------------------------------------------------------------------------
// spi_slave_sync
// SPI mode-0 (CPOL=0, CPHA=0), MSB-first slave sampled entirely in the clk
// domain. sck must run at clk/8 or slower.
// Optional feature: define SPI_SLAVE_SYNC_OVERRUN_EN to build the sticky
// overrun flag; otherwise overrun is tied low (dropping is unchanged).
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   ss_n, sck, mosi     - SPI bus inputs (asynchronous to clk)
//   miso, miso_oe       - serial data out and its drive enable
//   tx_data/valid/ready - transmit holding-register write handshake
//   rx_data/valid/ready - received-word handshake
//   overrun             - sticky flag: a word was dropped while rx_valid high
// ---------------------------------------------------------------------------
module spi_slave_sync
    import spi_slave_sync_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ss_n,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic ss_s, sck_s, mosi_s;
    logic ss_fall_s, ss_rise_s, sck_rise_s, sck_fall_s;
    logic load_s, tx_wr_s;

    spi_state_t       state_q, state_d;
    logic             ss_prev_q, sck_prev_q;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             boundary_q, boundary_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             miso_q, miso_d;
    logic             miso_oe_q, miso_oe_d;

    spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .d_i(ss_n), .q_o(ss_s)
    );
    spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d_i(sck), .q_o(sck_s)
    );
    spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s)
    );

    // edge detection, FSM, shifters, holding register and rx handshake next-state
    always_comb begin
        ss_fall_s  = ss_prev_q & ~ss_s;
        ss_rise_s  = ~ss_prev_q & ss_s;
        sck_rise_s = ~sck_prev_q & sck_s;
        sck_fall_s = sck_prev_q & ~sck_s;
        tx_wr_s    = tx_valid & ~hold_full_q;
        load_s     = 1'b0;

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        boundary_d  = boundary_q;
        done_d      = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;

        case (state_q)
            IDLE: begin
                if (ss_fall_s) begin
                    state_d    = ACTIVE;
                    load_s     = 1'b1;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    boundary_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (ss_rise_s) begin
                    // abort: partial rx and tx bits are discarded, holding kept
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                    boundary_d = 1'b0;
                end else if (sck_rise_s) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        bit_cnt_d  = '0;
                        done_d     = 1'b1;
                        boundary_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (sck_fall_s) begin
                    // first falling edge after a word boundary starts the next tx word
                    if (boundary_q) begin
                        load_s     = 1'b1;
                        boundary_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a load consumes the old holding contents before any same-cycle write
        if (load_s) begin
            tx_shift_d  = hold_full_q ? hold_q : '0;
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
        if (tx_wr_s) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end

        // word offered one cycle after completion; dropped if the old one is still pending
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        if (done_q && (!rx_valid_q || rx_ready)) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end else begin
            rx_data_d = rx_data_q;
        end

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
        if (rx_valid_q && rx_ready) begin
            overrun_d = 1'b0;
        end else if (done_q && rx_valid_q) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
`else
        overrun_d = 1'b0;
`endif

        miso_oe_d = (state_d == ACTIVE);
        miso_d    = (state_d == ACTIVE) ? tx_shift_d[WIDTH-1] : 1'b0;
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ss_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            boundary_q  <= 1'b0;
            done_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_prev_q   <= ss_s;
            sck_prev_q  <= sck_s;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            boundary_q  <= boundary_d;
            done_q      <= done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_sync
// Self-checking bench for spi_slave_sync: table of single-byte transfers plus
// hand-written back-to-back, abort, overrun and mid-word reset sequences.
// sck runs at clk/8 (4 clk low, 4 clk high). Honours SPI_SLAVE_SYNC_OVERRUN_EN.
// ---------------------------------------------------------------------------
module tb_spi_slave_sync;

    localparam int W = 8;

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    typedef struct {
        logic         has_tx;
        logic [W-1:0] tx;
        logic [W-1:0] mo;
        logic [W-1:0] exp_miso;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ss_n = 1'b1;
    logic         sck = 1'b0;
    logic         mosi = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         rx_ready = 1'b0;
    logic         miso, miso_oe, tx_ready, rx_valid, overrun;
    logic [W-1:0] rx_data;

    int errs = 0;
    int checks = 0;

    spi_slave_sync #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // master: n bits MSB first; mosi changes with sck low, miso sampled just before the rise
    task automatic spi_bits(input logic [W-1:0] b, input int n, output logic [W-1:0] m);
        m = '0;
        for (int i = 0; i < n; i++) begin
            mosi = b[W-1-i];
            tick(4);
            m[W-1-i] = miso;
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic wait_rx(input string name);
        int k = 0;
        while (!rx_valid && k < 16) begin
            tick(1);
            k++;
        end
        chk(name, 32'(rx_valid), 32'h1);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("rx_valid_fall", 32'(rx_valid), 32'h0);
    endtask

    task automatic preload(input logic [W-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("tx_ready_full", 32'(tx_ready), 32'h0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_miso", 32'(miso), 32'h0);
        chk("rst_miso_oe", 32'(miso_oe), 32'h0);
        chk("rst_tx_ready", 32'(tx_ready), 32'h1);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt[3];
        logic [W-1:0] m1, m2;

        vt[0] = '{has_tx: 1'b1, tx: 8'hA5, mo: 8'h3C, exp_miso: 8'hA5};
        vt[1] = '{has_tx: 1'b0, tx: 8'h00, mo: 8'hC3, exp_miso: 8'h00};
        vt[2] = '{has_tx: 1'b1, tx: 8'h0F, mo: 8'hF0, exp_miso: 8'h0F};

        tick(3);
        chk_reset_outputs();
        rst = 1'b0;
        tick(4);

        // table: single byte per ss_n frame
        for (int v = 0; v < 3; v++) begin
            if (vt[v].has_tx) begin
                preload(vt[v].tx);
            end
            ss_n = 1'b0;
            tick(8);
            chk("miso_oe_on", 32'(miso_oe), 32'h1);
            chk("tx_ready_after_load", 32'(tx_ready), 32'h1);
            spi_bits(vt[v].mo, 8, m1);
            chk("miso_byte", 32'(m1), 32'(vt[v].exp_miso));
            wait_rx("rx_valid_rise");
            chk("rx_data", 32'(rx_data), 32'(vt[v].mo));
            chk("tx_ready_end", 32'(tx_ready), 32'h1);
            tick(2);
            ss_n = 1'b1;
            tick(8);
            chk("miso_oe_off", 32'(miso_oe), 32'h0);
            chk("miso_idle", 32'(miso), 32'h0);
            accept();
        end

        // back-to-back: two words under one ss_n, second tx written after first load
        preload(8'h55);
        ss_n = 1'b0;
        tick(8);
        chk("b2b_tx_ready", 32'(tx_ready), 32'h1);
        preload(8'hAA);
        spi_bits(8'h01, 8, m1);
        chk("b2b_miso1", 32'(m1), 32'h55);
        wait_rx("b2b_rx1_valid");
        chk("b2b_rx1", 32'(rx_data), 32'h01);
        accept();
        spi_bits(8'hFF, 8, m2);
        chk("b2b_miso2", 32'(m2), 32'hAA);
        wait_rx("b2b_rx2_valid");
        chk("b2b_rx2", 32'(rx_data), 32'hFF);
        tick(2);
        ss_n = 1'b1;
        tick(8);
        accept();

        // abort after 5 bits, then a full byte must still frame correctly
        ss_n = 1'b0;
        tick(8);
        spi_bits(8'hE7, 5, m1);
        ss_n = 1'b1;
        tick(16);
        chk("abort_no_rx", 32'(rx_valid), 32'h0);
        ss_n = 1'b0;
        tick(8);
        spi_bits(8'h81, 8, m1);
        wait_rx("abort_next_valid");
        chk("abort_next_rx", 32'(rx_data), 32'h81);
        tick(2);
        ss_n = 1'b1;
        tick(8);
        accept();

        // overrun: second word arrives while the first is still pending
        ss_n = 1'b0;
        tick(8);
        spi_bits(8'h11, 8, m1);
        wait_rx("ovr_rx1_valid");
        spi_bits(8'h22, 8, m1);
        tick(6);
        chk("ovr_rx_kept", 32'(rx_data), 32'h11);
        chk("ovr_valid_held", 32'(rx_valid), 32'h1);
        chk("ovr_flag", 32'(overrun), 32'(EXP_OVR));
        tick(2);
        ss_n = 1'b1;
        tick(8);
        accept();
        chk("ovr_cleared", 32'(overrun), 32'h0);
        chk("ovr_rx_after_accept", 32'(rx_data), 32'h11);

        // reset pulsed mid-word with a full holding register
        ss_n = 1'b0;
        tick(8);
        preload(8'h99);
        spi_bits(8'hF0, 3, m1);
        rst = 1'b1;
        tick(2);
        chk_reset_outputs();
        ss_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(8);
        chk("rst_no_rx", 32'(rx_valid), 32'h0);
        chk("rst_idle_oe", 32'(miso_oe), 32'h0);
        ss_n = 1'b0;
        tick(8);
        spi_bits(8'h5A, 8, m1);
        chk("rst_next_miso", 32'(m1), 32'h00);
        wait_rx("rst_next_valid");
        chk("rst_next_rx", 32'(rx_data), 32'h5A);
        tick(2);
        ss_n = 1'b1;
        tick(8);
        accept();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
